// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// state codes, ALU control codes and datapath mux select codes.
package mips_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned WAIT_W = 8;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_BNE     = 4'd12,
        ST_ILLEGAL = 4'd14,
        ST_TIMEOUT = 4'd15
    } state_t;

    // States that hold a memory request open and may stall on mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU decoder: maps ALUOp and funct to alu_control, flagging unknown R-type functs.
module mips_alu_dec
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: illegal     = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with req/ready memory handshake, timeout and stall counter.
// Optional macro MIPS_BNE_EN adds a BNE state (code 12) for op 000101.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_control,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             error,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t            state_q;
    state_t            state_d;
    alu_op_t           alu_op;
    logic              alu_illegal;
    logic              pc_write;
    logic              branch;
    logic              branch_cond;
    logic              timeout_hit;
    logic [WAIT_W-1:0] wait_cnt;
    logic              error_q;
    logic [CNT_W-1:0]  stall_q;

    mips_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control),
        .illegal     (alu_illegal)
    );

    // ALUOp depends on state only, kept apart from the next-state logic.
    always_comb begin
        alu_op = ALUOP_ADD;
        case (state_q)
            ST_EXECUTE:       alu_op = ALUOP_FUNCT;
            ST_BRANCH, ST_BNE: alu_op = ALUOP_SUB;
            default:          alu_op = ALUOP_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            error_q  <= 1'b0;
            stall_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d == ST_ILLEGAL) || (state_d == ST_TIMEOUT)) begin
                error_q <= 1'b1;
            end
            if (mem_req && !mem_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            // Wait count lives only as long as the current wait state.
            if (is_wait_state(state_q) && (state_d == state_q) && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        pc_src      = PCSRC_ALU;
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_cond = zero;
        timeout_hit = is_wait_state(state_q) && !mem_ready &&
                      (wait_cnt == WAIT_W'(MAX_WAIT));

        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (op)
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
`ifdef MIPS_BNE_EN
                    OP_BNE:       state_d = ST_BNE;
`endif
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = !timeout_hit;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                state_d   = alu_illegal ? ST_ILLEGAL : ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
                state_d   = ST_FETCH;
            end
`ifdef MIPS_BNE_EN
            ST_BNE: begin
                alu_src_a   = 1'b1;
                pc_src      = PCSRC_ALUOUT;
                branch      = 1'b1;
                branch_cond = !zero;
                state_d     = ST_FETCH;
            end
`endif
            ST_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_ILLEGAL, ST_TIMEOUT: state_d = state_q;
            default:                state_d = ST_ILLEGAL;
        endcase

        if (timeout_hit) state_d = ST_TIMEOUT;

        // Synchronous reset still silences every enable in the reset cycle.
        if (reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
            branch    = 1'b0;
        end
        pc_en = pc_write | (branch & branch_cond);
    end

    assign state        = 4'(state_q);
    assign error        = error_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl (MAX_WAIT = 15, CNT_W = 16).
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'b0;
    logic [5:0]  funct = 6'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, iord, mem_write, ir_write, reg_write, reg_dst;
    logic        mem_to_reg, alu_src_a, pc_en, error;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic [3:0]  state;
    logic [15:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    int irw_cnt = 0;
    int rw_cnt  = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .iord         (iord),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .pc_src       (pc_src),
        .alu_control  (alu_control),
        .pc_en        (pc_en),
        .state        (state),
        .error        (error),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        #1;
        check("rst_cycle_mem_req", 32'(mem_req), 0);
        check("rst_cycle_pc_en", 32'(pc_en), 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_error", 32'(error), 0);
        check("rst_stall", 32'(stall_cycles), 0);
    endtask

    // One-cycle fetch then decode; leaves the FSM in the post-decode state.
    task automatic fetch_decode(input logic [5:0] op_v);
        op        = op_v;
        mem_ready = 1'b1;
        #1;
        check("fd_fetch_state", 32'(state), 0);
        tick();
        mem_ready = 1'b0;
        #1;
        check("fd_decode_state", 32'(state), 1);
        check("fd_decode_srcb", 32'(alu_src_b), 3);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // lw with three stall cycles in both FETCH and MEMRD
        op = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("lw_fetch_state", 32'(state), 0);
            if (ir_write) irw_cnt++;
            if (reg_write) rw_cnt++;
            tick();
        end
        mem_ready = 1'b0;
        #1;
        check("lw_decode_state", 32'(state), 1);
        tick();
        #1;
        check("lw_memadr_state", 32'(state), 2);
        check("lw_memadr_srcb", 32'(alu_src_b), 2);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("lw_memrd_state", 32'(state), 3);
            check("lw_memrd_iord", 32'(iord), 1);
            if (ir_write) irw_cnt++;
            if (reg_write) rw_cnt++;
            tick();
        end
        mem_ready = 1'b0;
        #1;
        check("lw_memwb_state", 32'(state), 4);
        check("lw_memwb_m2r", 32'(mem_to_reg), 1);
        if (reg_write) rw_cnt++;
        tick();
        #1;
        check("lw_back_fetch", 32'(state), 0);
        check("lw_irw_pulses", 32'(irw_cnt), 1);
        check("lw_rw_pulses", 32'(rw_cnt), 1);
        check("lw_stall", 32'(stall_cycles), 6);

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            fetch_decode(6'b000100);
            zero = z[0];
            #1;
            check("beq_state", 32'(state), 8);
            check("beq_pc_en", 32'(pc_en), 32'(z));
            check("beq_pc_src", 32'(pc_src), 1);
            check("beq_alu_ctl", 32'(alu_control), 6);
            tick();
            #1;
            check("beq_back_fetch", 32'(state), 0);
        end
        zero = 1'b0;

        // R-type slt
        funct = 6'b101010;
        fetch_decode(6'b000000);
        #1;
        check("slt_exec_state", 32'(state), 6);
        check("slt_alu_ctl", 32'(alu_control), 7);
        tick();
        #1;
        check("slt_aluwb_state", 32'(state), 7);
        check("slt_reg_dst", 32'(reg_dst), 1);
        check("slt_reg_write", 32'(reg_write), 1);
        tick();

        // addi and jump
        fetch_decode(6'b001000);
        #1;
        check("addi_ex_state", 32'(state), 9);
        check("addi_ex_srcb", 32'(alu_src_b), 2);
        tick();
        #1;
        check("addi_wb_state", 32'(state), 10);
        check("addi_wb_rw", 32'(reg_write), 1);
        check("addi_wb_dst", 32'(reg_dst), 0);
        tick();
        fetch_decode(6'b000010);
        #1;
        check("j_state", 32'(state), 11);
        check("j_pc_en", 32'(pc_en), 1);
        check("j_pc_src", 32'(pc_src), 2);
        tick();

        // illegal funct is terminal
        funct = 6'b000111;
        fetch_decode(6'b000000);
        tick();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ill_state", 32'(state), 14);
            check("ill_error", 32'(error), 1);
            check("ill_mem_req", 32'(mem_req), 0);
            check("ill_reg_write", 32'(reg_write), 0);
            tick();
        end
        do_reset();

        // memory never ready: timeout after count reaches 15
        for (int i = 0; i < 16; i++) begin
            #1;
            if (i == 15) check("to_last_irw", 32'(ir_write), 0);
            tick();
        end
        #1;
        check("to_state", 32'(state), 15);
        check("to_error", 32'(error), 1);
        check("to_stall", 32'(stall_cycles), 16);
        tick();
        tick();
        check("to_hold_state", 32'(state), 15);
        check("to_hold_mem_req", 32'(mem_req), 0);
        check("to_hold_stall", 32'(stall_cycles), 16);
        do_reset();

        // ready on the count-15 cycle completes the fetch
        op = 6'b101011;
        for (int i = 0; i < 16; i++) begin
            mem_ready = (i == 15);
            #1;
            if (i == 15) check("edge_irw", 32'(ir_write), 1);
            tick();
        end
        mem_ready = 1'b0;
        #1;
        check("edge_state", 32'(state), 1);
        check("edge_error", 32'(error), 0);
        check("edge_stall", 32'(stall_cycles), 15);
        tick();
        #1;
        check("sw_memadr_state", 32'(state), 2);
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("sw_wait_state", 32'(state), 5);
            check("sw_wait_mem_write", 32'(mem_write), 1);
            tick();
        end
        check("sw_wait_stall", 32'(stall_cycles), 17);

        // reset mid MEMWR wait
        reset = 1'b1;
        #1;
        check("rst_mid_mem_write", 32'(mem_write), 0);
        check("rst_mid_mem_req", 32'(mem_req), 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_state", 32'(state), 0);
        check("rst_mid_stall", 32'(stall_cycles), 0);
        check("rst_mid_mem_write2", 32'(mem_write), 0);

        // sw completing immediately
        fetch_decode(6'b101011);
        tick();
        mem_ready = 1'b1;
        #1;
        check("sw_ready_state", 32'(state), 5);
        check("sw_ready_mem_write", 32'(mem_write), 1);
        tick();
        mem_ready = 1'b0;
        #1;
        check("sw_done_state", 32'(state), 0);
        check("sw_done_mem_write", 32'(mem_write), 0);

        // op 000101 with zero = 0
        fetch_decode(6'b000101);
        zero = 1'b0;
        #1;
`ifdef MIPS_BNE_EN
        check("bne_state", 32'(state), 12);
        check("bne_pc_en", 32'(pc_en), 1);
`else
        check("bne_off_state", 32'(state), 14);
        check("bne_off_error", 32'(error), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Next-generation multicycle MIPS control unit with a parametrised memory wait-state handshake (req/ready) in place of fixed single-cycle memory.
- Adds addi and j, illegal-opcode trapping, a memory-timeout error state and a saturating stall counter.
- Sits between the datapath (op, funct, zero in; mux/enable strobes out) and the memory port.

Parameters:
- MAX_WAIT, 15, max consecutive cycles waiting on mem_ready before timeout (1..255).
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instruction[31:26].
- funct  input  6  instruction[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the access this cycle.
- mem_req  output  1  memory access request.
- iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes and mux selects.
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- pc_src  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_en  output  1  pc_write | (branch & branch-condition).
- state  output  4  current state.
- error  output  1  sticky; set in ILLEGAL/TIMEOUT.
- stall_cycles  output  CNT_W  saturating count of mem_req & !mem_ready cycles.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, on port reset.
- Reset (synchronous, dominates everything, including mid-wait):
  - state = FETCH.
  - error, stall_cycles and wait counter cleared.
  - All strobes 0 in the reset cycle.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 14, TIMEOUT 15.
- Outputs are Moore (functions of state) except the ready-qualified strobes and pc_en.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_control = add, pc_src = 00.
  - ir_write and pc_write assert only in the cycle mem_ready = 1; then go to DECODE. Otherwise hold.
- DECODE: alu_src_b = 11, alu_control = add. Next state by op:
  - 000000 → EXECUTE
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - other → ILLEGAL
- MEMADR: alu_src_a = 1, alu_src_b = 10, add. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req = 1, iord = 1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next FETCH.
- MEMWR: mem_req = 1, iord = 1. mem_write is asserted for the whole wait and drops after the ready cycle. Next FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_control from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Other funct → ILLEGAL; no writeback.
- ALUWB: reg_write = 1, reg_dst = 1. Next FETCH.
- BRANCH: alu_src_a = 1, sub, pc_src = 01, branch = 1 (pc_en = zero). Next FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, add. ADDIWB: reg_write = 1, reg_dst = 0. Next FETCH.
- JUMP: pc_src = 10, pc_write = 1. Next FETCH.
- Wait counter:
  - Counts cycles in FETCH/MEMRD/MEMWR with !mem_ready; cleared on state exit.
  - When it reaches MAX_WAIT with mem_ready still 0, go to TIMEOUT next cycle; no strobes fire.
  - mem_ready on the same cycle as count == MAX_WAIT wins (access completes).
- ILLEGAL/TIMEOUT:
  - Terminal until reset; error = 1; all strobes 0, mem_req = 0.
- stall_cycles: +1 per mem_req & !mem_ready cycle; saturates at all-ones.
- mem_ready while mem_req = 0 is ignored.

Optional Feature:
- Macro MIPS_BNE_EN.
- Defined: op 000101 decodes to BNE state (12): as BRANCH but pc_en = !zero.
- Undefined: op 000101 → ILLEGAL; state code 12 unused.

Decomposition:
- Package mips_pkg: opcode/funct constants, state encodings, alu_control codes, alu_src_b/pc_src select codes.
- One natural sub-module, mips_alu_dec (funct + ALUOp → alu_control + illegal flag, combinational).

Test Plan:
- lw with mem_ready held 0 for 3 cycles in FETCH and MEMRD → each state held 4 cycles; ir_write and reg_write pulse once; stall_cycles = 6; states 0,1,2,3,4,0.
- beq, zero = 1 → pc_en = 1 in BRANCH with pc_src = 01. Same with zero = 0 → pc_en = 0. Both return to FETCH.
- R-type funct 101010 → alu_control = 111 in EXECUTE, reg_dst = 1 in ALUWB. funct 000111 → state 14, error = 1, stays until reset.
- mem_ready tied 0 with MAX_WAIT = 15 → TIMEOUT after 15 wait cycles. With mem_ready = 1 exactly on count 15 → DECODE, no error.
- reset asserted mid-MEMWR wait → next state FETCH, mem_write = 0, stall_cycles = 0.
- op 000101, zero = 0: with MIPS_BNE_EN → state 12, pc_en = 1. Without → state 14.
